recompute_feeder: RTL and testbench
===================================

# recompute_feeder

Upstream stage of the BISR recompute path in the systolic array. It accepts a single faulty-PE location from the BIST controller and captures that PE's stationary weight. While active, it reconstructs the operands the faulty PE would have seen:
- its skewed west-edge activation
- the partial sum arriving from the PE above

It drives these, with one-hot fault markers, into `recompute_unit` every cycle until BIST clears the fault.

## Interface
- `WORD_SIZE`, 16, datapath word width
- `ROWS`, 4, PE rows in array
- `COLS`, 4, PE columns in array
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-low reset
- `fault_valid`  in  1  BIST presents a fault location
- `fault_ready`  out  1  feeder can accept a location (high only in IDLE)
- `fault_row`  in  $clog2(ROWS)  faulty PE row index
- `fault_col`  in  $clog2(COLS)  faulty PE column index
- `fault_clear`  in  1  BIST ends recompute for current fault
- `weight_bus`  in  ROWS*COLS*WORD_SIZE  all PE weights; PE(r,c) at slice `(r*COLS+c)*WORD_SIZE`
- `left_bus`  in  ROWS*WORD_SIZE  unskewed west-edge activations, row r at slice `r*WORD_SIZE`
- `psum_bus`  in  ROWS*COLS*WORD_SIZE  BottomOut of every PE, same indexing as `weight_bus`
- `Weight`, `TopIn`, `LeftIn`  out  WORD_SIZE each  operands to `recompute_unit`
- `faultyRowOut`  out  ROWS  one-hot faulty row
- `faultyColOut`  out  COLS  one-hot faulty column
- `recompute_en`  out  1  operands valid this cycle
- `fault_err`  out  1  one-cycle pulse: location out of range, rejected

## Operation
- States:
  - IDLE: waiting for a fault location.
  - LOAD: weight capture.
  - ACTIVE: operand streaming.
  - DRAIN: flush downstream pipeline.
- IDLE → LOAD on `fault_valid && fault_ready`.
  - `fault_row`/`fault_col` are latched on that edge.
  - If `fault_row >= ROWS` or `fault_col >= COLS`: stay in IDLE, pulse `fault_err`, latch nothing.
- LOAD → ACTIVE unconditionally after 1 cycle.
  - `Weight` <= weight of PE(row,col).
  - `faultyRowOut`/`faultyColOut` <= one-hot of latched indices.
- ACTIVE, every cycle:
  - `recompute_en`=1.
  - `LeftIn` <= left_bus[row] delayed by `col` cycles (registered, so total latency col+1).
  - `TopIn` <= psum of PE(row-1,col), or 0 when row==0.
- ACTIVE → DRAIN on `fault_clear`.
  - `recompute_en` drops on the same edge.
  - `Weight` and markers hold.
- DRAIN lasts exactly COLS+2 cycles (down-counter), then → IDLE.
  - On entering IDLE: `Weight`, `TopIn`, `LeftIn` and markers zeroed.
- `fault_clear` outside ACTIVE is ignored. `fault_valid` outside IDLE is ignored (`fault_ready`=0).
- Activation delay line:
  - ROWS lanes × (COLS-1) stages.
  - Shifts every cycle in every state, from reset onward, so taps are valid on the first ACTIVE cycle.
- Pure data routing; no arithmetic. Widths are preserved, with no truncation or extension.

## Timing
- Reset (`rst`=0 at an edge):
  - State → IDLE, `fault_ready`=1.
  - All other outputs and all delay-line stages → 0.
  - DRAIN counter → 0.
- Reset mid-ACTIVE or mid-DRAIN aborts immediately: no drain, outputs 0 the next cycle.
- Accept edge T: LOAD at T+1; `Weight` and markers valid from T+2.
- First `recompute_en`=1 cycle is T+2.
- `LeftIn` at cycle n equals `left_bus[row]` sampled at cycle n-1-col.
- `TopIn` at cycle n equals `psum_bus` sampled at cycle n-1.
- `fault_clear` at edge C: `recompute_en`=0 from C; `fault_ready`=1 at C+COLS+3.
- `fault_err` is asserted the cycle after the rejected handshake, for one cycle.

## Structure
- Shared package `bisr_pkg` holds:
  - the state enum `feeder_state_t`
  - the helper function `onehot_row`/`onehot_col`
  - the `DRAIN_CYCLES` constant (COLS+2), which `recompute_unit`-side logic also references
- One natural sub-module: `skew_delay_line` (parameterised DEPTH, WORD_SIZE; exposes all taps).
  - Instantiated once per row.

## Test plan
- Reset then idle: `rst` low 2 cycles → all outputs 0, `fault_ready`=1, `recompute_en`=0.
- Fault (2,3), weights PE(r,c)=16*r+c, `left_bus[2]` ramp 1,2,3… → `Weight`=35, `faultyRowOut`=4'b0100, `faultyColOut`=4'b1000; `LeftIn` trails the ramp by 4 cycles; `TopIn` tracks PE(1,3) psum 1 cycle late.
- Fault (0,0) → `TopIn`=0 throughout ACTIVE; `LeftIn` = `left_bus[0]` delayed 1 cycle.
- `fault_row`=5 with ROWS=4 → `fault_err` 1-cycle pulse, state stays IDLE, outputs unchanged.
- `fault_clear` in ACTIVE, then `fault_valid` during DRAIN → ignored; `fault_ready` returns exactly 7 cycles after clear (COLS=4); a new fault is then accepted.
- `rst` asserted mid-ACTIVE → next cycle all outputs 0, IDLE; the delay line restarts from zero.

Source files
------------

// File: rtl/bisr_pkg.sv
// Shared BISR recompute-path types and constants: feeder FSM states, one-hot helpers, drain length.
package bisr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ACTIVE,
    ST_DRAIN
  } feeder_state_t;

  localparam int ARRAY_COLS = 4;
  localparam int MARK_W     = 32;

  function automatic int drain_len(input int cols);
    return cols + 2;
  endfunction

  // Downstream pipeline depth the feeder waits out after fault_clear.
  localparam int DRAIN_CYCLES = drain_len(ARRAY_COLS);

  function automatic logic [MARK_W-1:0] onehot_row(input int idx);
    return MARK_W'(1) << idx;
  endfunction

  function automatic logic [MARK_W-1:0] onehot_col(input int idx);
    return MARK_W'(1) << idx;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Per-row activation shift register; tap k is din_i delayed k cycles (tap 0 is the live input).
// Shifts every cycle regardless of feeder state; synchronous active-low reset clears all stages.
module skew_delay_line #(
  parameter int DEPTH     = 3,
  parameter int WORD_SIZE = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [WORD_SIZE-1:0]           din_i,
  output logic [(DEPTH+1)*WORD_SIZE-1:0] taps_o
);

  logic [DEPTH*WORD_SIZE-1:0] stage_q, stage_d;

  always_comb begin
    stage_d = stage_q;
    stage_d[WORD_SIZE-1:0] = din_i;
    for (int k = 1; k < DEPTH; k++) begin
      stage_d[k*WORD_SIZE +: WORD_SIZE] = stage_q[(k-1)*WORD_SIZE +: WORD_SIZE];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign taps_o = {stage_q, din_i};

endmodule

// File: rtl/recompute_feeder.sv
// Rebuilds the weight, skewed west activation and north partial sum of one faulty PE for recompute_unit.
// Operands valid two edges after the accepted handshake; COLS+2 drain cycles follow fault_clear.
module recompute_feeder
  import bisr_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int ROWS      = 4,
  parameter int COLS      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           fault_valid,
  output logic                           fault_ready,
  // One spare index bit so an out-of-range location can be presented and rejected.
  input  logic [$clog2(ROWS+1)-1:0]      fault_row,
  input  logic [$clog2(COLS+1)-1:0]      fault_col,
  input  logic                           fault_clear,
  input  logic [ROWS*COLS*WORD_SIZE-1:0] weight_bus,
  input  logic [ROWS*WORD_SIZE-1:0]      left_bus,
  input  logic [ROWS*COLS*WORD_SIZE-1:0] psum_bus,
  output logic [WORD_SIZE-1:0]           Weight,
  output logic [WORD_SIZE-1:0]           TopIn,
  output logic [WORD_SIZE-1:0]           LeftIn,
  output logic [ROWS-1:0]                faultyRowOut,
  output logic [COLS-1:0]                faultyColOut,
  output logic                           recompute_en,
  output logic                           fault_err
);

  localparam int RIW       = $clog2(ROWS + 1);
  localparam int CIW       = $clog2(COLS + 1);
  localparam int DRAIN_LEN = drain_len(COLS);
  localparam int CW        = $clog2(DRAIN_LEN);

  feeder_state_t        state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [RIW-1:0]       row_q, row_d;
  logic [CIW-1:0]       col_q, col_d;
  logic [WORD_SIZE-1:0] weight_q, weight_d;
  logic [WORD_SIZE-1:0] top_q, top_d;
  logic [WORD_SIZE-1:0] left_q, left_d;
  logic [ROWS-1:0]      rmark_q, rmark_d;
  logic [COLS-1:0]      cmark_q, cmark_d;
  logic                 err_q, err_d;

  logic [ROWS*COLS*WORD_SIZE-1:0] tap_flat;
  int                             pe_sel;
  logic [WORD_SIZE-1:0]           top_src;

  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    skew_delay_line #(
      .DEPTH     (COLS - 1),
      .WORD_SIZE (WORD_SIZE)
    ) u_skew (
      .clk_i  (clk),
      .rst_ni (rst),
      .din_i  (left_bus[r*WORD_SIZE +: WORD_SIZE]),
      .taps_o (tap_flat[r*COLS*WORD_SIZE +: COLS*WORD_SIZE])
    );
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    col_d    = col_q;
    weight_d = weight_q;
    top_d    = top_q;
    left_d   = left_q;
    rmark_d  = rmark_q;
    cmark_d  = cmark_q;
    err_d    = 1'b0;
    // Taps and PEs share the row*COLS+col layout, so one selector serves both.
    pe_sel   = int'(row_q) * COLS + int'(col_q);
    top_src  = (row_q == '0) ? '0 : psum_bus[(pe_sel - COLS)*WORD_SIZE +: WORD_SIZE];

    unique case (state_q)
      ST_IDLE: begin
        if (fault_valid) begin
          if (int'(fault_row) >= ROWS || int'(fault_col) >= COLS) begin
            err_d = 1'b1;
          end else begin
            row_d   = fault_row;
            col_d   = fault_col;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        weight_d = weight_bus[pe_sel*WORD_SIZE +: WORD_SIZE];
        rmark_d  = ROWS'(onehot_row(int'(row_q)));
        cmark_d  = COLS'(onehot_col(int'(col_q)));
        top_d    = top_src;
        left_d   = tap_flat[pe_sel*WORD_SIZE +: WORD_SIZE];
        state_d  = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (fault_clear) begin
          cnt_d   = CW'(DRAIN_LEN - 1);
          state_d = ST_DRAIN;
        end else begin
          top_d  = top_src;
          left_d = tap_flat[pe_sel*WORD_SIZE +: WORD_SIZE];
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          weight_d = '0;
          top_d    = '0;
          left_d   = '0;
          rmark_d  = '0;
          cmark_d  = '0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      weight_q <= '0;
      top_q    <= '0;
      left_q   <= '0;
      rmark_q  <= '0;
      cmark_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      col_q    <= col_d;
      weight_q <= weight_d;
      top_q    <= top_d;
      left_q   <= left_d;
      rmark_q  <= rmark_d;
      cmark_q  <= cmark_d;
      err_q    <= err_d;
    end
  end

  assign fault_ready  = (state_q == ST_IDLE);
  assign recompute_en = (state_q == ST_ACTIVE);
  assign Weight       = weight_q;
  assign TopIn        = top_q;
  assign LeftIn       = left_q;
  assign faultyRowOut = rmark_q;
  assign faultyColOut = cmark_q;
  assign fault_err    = err_q;

endmodule

// File: tb/tb_recompute_feeder.sv
// Bench for recompute_feeder: edge-indexed reference model plus directed scenarios with literal expectations.
module tb_recompute_feeder;

  localparam int W    = 16;
  localparam int R    = 4;
  localparam int C    = 4;
  localparam int HMAX = 1024;
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_ACT = 2, PH_DRAIN = 3;

  logic           clk;
  logic           rst;
  logic           fault_valid;
  logic           fault_ready;
  logic [2:0]     fault_row;
  logic [2:0]     fault_col;
  logic           fault_clear;
  logic [R*C*W-1:0] weight_bus;
  logic [R*W-1:0]   left_bus;
  logic [R*C*W-1:0] psum_bus;
  logic [W-1:0]   Weight, TopIn, LeftIn;
  logic [R-1:0]   faultyRowOut;
  logic [C-1:0]   faultyColOut;
  logic           recompute_en;
  logic           fault_err;

  recompute_feeder #(.WORD_SIZE(W), .ROWS(R), .COLS(C)) dut (
    .clk          (clk),
    .rst          (rst),
    .fault_valid  (fault_valid),
    .fault_ready  (fault_ready),
    .fault_row    (fault_row),
    .fault_col    (fault_col),
    .fault_clear  (fault_clear),
    .weight_bus   (weight_bus),
    .left_bus     (left_bus),
    .psum_bus     (psum_bus),
    .Weight       (Weight),
    .TopIn        (TopIn),
    .LeftIn       (LeftIn),
    .faultyRowOut (faultyRowOut),
    .faultyColOut (faultyColOut),
    .recompute_en (recompute_en),
    .fault_err    (fault_err)
  );

  int errors = 0;
  int checks = 0;
  int ramp   = 0;
  int cyc    = 0;

  // Model: input history per edge plus the edges at which events happened.
  logic [R*W-1:0]   lhist [HMAX];
  logic [R*C*W-1:0] phist [HMAX];
  logic [R*C*W-1:0] whist [HMAX];
  int m_acc = -1, m_clr = -1, m_err = -100, m_rst = -1, m_row = 0, m_col = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: no summary after 200000 time units");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc - 1);
    end
  endtask

  // State expected after edge k, derived purely from event edges and the drain length COLS+2.
  function automatic int model_phase(input int k);
    if (m_acc < 0 || k < m_acc) return PH_IDLE;
    if (k == m_acc) return PH_LOAD;
    if (m_clr < 0 || k < m_clr) return PH_ACT;
    if (k < m_clr + C + 2) return PH_DRAIN;
    return PH_IDLE;
  endfunction

  function automatic logic [W-1:0] left_at(input int j, input int r);
    if (j < 0 || j <= m_rst) return '0;
    return lhist[j][r*W +: W];
  endfunction

  task automatic drive_data();
    for (int r = 0; r < R; r++) begin
      left_bus[r*W +: W] = 16'(ramp + ((r + 2) % 4) * 4096);
      for (int c = 0; c < C; c++) psum_bus[(r*C+c)*W +: W] = 16'(16384 + ramp*16 + r*4 + c);
    end
  endtask

  initial begin : driver
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) weight_bus[(r*C+c)*W +: W] = 16'(16*r + c);
    ramp = 1;
    drive_data();
    forever begin
      @(posedge clk);
      #1;
      ramp++;
      drive_data();
    end
  end

  initial begin : monitor
    int ph;
    forever begin
      @(posedge clk);
      lhist[cyc] = left_bus;
      phist[cyc] = psum_bus;
      whist[cyc] = weight_bus;
      if (!rst) begin
        m_acc = -1; m_clr = -1; m_err = -100; m_rst = cyc;
      end else begin
        ph = model_phase(cyc - 1);
        if (ph == PH_IDLE && fault_valid) begin
          if (fault_row >= 3'd4 || fault_col >= 3'd4) m_err = cyc;
          else begin
            m_acc = cyc; m_clr = -1; m_row = int'(fault_row); m_col = int'(fault_col);
          end
        end else if (ph == PH_ACT && fault_clear) begin
          m_clr = cyc;
        end
      end
      if (cyc < HMAX - 1) cyc++;
    end
  end

  initial begin : compare
    int k, ph;
    logic [W-1:0] e_w, e_left, e_top;
    logic [R-1:0] e_rm;
    logic [C-1:0] e_cm;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        k  = cyc - 1;
        ph = model_phase(k);
        e_w = '0; e_rm = '0; e_cm = '0; e_left = '0; e_top = '0;
        if (ph == PH_ACT || ph == PH_DRAIN) begin
          e_w  = whist[m_acc+1][(m_row*C + m_col)*W +: W];
          e_rm = 4'b0001 << m_row;
          e_cm = 4'b0001 << m_col;
        end
        if (ph == PH_ACT) begin
          e_left = left_at(k - m_col, m_row);
          if (m_row != 0) e_top = phist[k][((m_row-1)*C + m_col)*W +: W];
        end
        check("m_ready", fault_ready, ph == PH_IDLE);
        check("m_en", recompute_en, ph == PH_ACT);
        check("m_err", fault_err, k == m_err);
        check("m_weight", Weight, e_w);
        check("m_rowmark", faultyRowOut, e_rm);
        check("m_colmark", faultyColOut, e_cm);
        if (ph != PH_DRAIN) begin
          check("m_left", LeftIn, e_left);
          check("m_top", TopIn, e_top);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, fault_ready, 1);
    check({tag, "_en"}, recompute_en, 0);
    check({tag, "_w"}, Weight, 0);
    check({tag, "_left"}, LeftIn, 0);
    check({tag, "_top"}, TopIn, 0);
    check({tag, "_marks"}, {faultyRowOut, faultyColOut}, 0);
  endtask

  initial begin : stimulus
    int n;
    logic [2:0] bad_r [2];
    logic [2:0] bad_c [2];
    bad_r[0] = 3'd5; bad_c[0] = 3'd1;
    bad_r[1] = 3'd1; bad_c[1] = 3'd4;
    rst = 1'b0; fault_valid = 1'b0; fault_row = '0; fault_col = '0; fault_clear = 1'b0;

    step(); step();
    check_all_zero("reset");
    check("reset_err", fault_err, 0);
    rst = 1'b1;
    repeat (4) step();

    // Fault (2,3): weight 35, LeftIn trails the row-2 ramp by 4, TopIn is PE(1,3) psum one cycle late.
    fault_valid = 1'b1; fault_row = 3'd2; fault_col = 3'd3;
    step();
    fault_valid = 1'b0;
    check("load_ready", fault_ready, 0);
    check("load_en", recompute_en, 0);
    step();
    check("w_35", Weight, 35);
    check("rowmark_0100", faultyRowOut, 4'b0100);
    check("colmark_1000", faultyColOut, 4'b1000);
    for (int i = 0; i < 6; i++) begin
      check("left_trail4", LeftIn, 16'(ramp - 4));
      check("top_pe13", TopIn, 16'(16384 + (ramp - 1)*16 + 7));
      check("en_active", recompute_en, 1);
      step();
    end

    // Clear, then a fault offered during drain must wait until ready returns.
    fault_clear = 1'b1;
    step();
    fault_clear = 1'b0;
    check("clr_en", recompute_en, 0);
    check("drain_w_hold", Weight, 35);
    fault_valid = 1'b1; fault_row = 3'd0; fault_col = 3'd0;
    n = 1;
    while (!fault_ready && n < 20) begin
      step();
      n++;
    end
    check("ready_7_after_clear", n, 7);
    check_all_zero("idle_after_drain");

    // Fault (0,0): TopIn is 0, LeftIn is row 0 delayed one cycle.
    step();
    fault_valid = 1'b0;
    check("load2_ready", fault_ready, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      check("top_row0", TopIn, 0);
      check("left_col0", LeftIn, 16'(ramp - 1 + 8192));
      check("rowmark_0001", faultyRowOut, 4'b0001);
      step();
    end

    // Reset mid-ACTIVE: immediate abort, delay line restarts from zero.
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_all_zero("midreset");
    fault_valid = 1'b1; fault_row = 3'd2; fault_col = 3'd3;
    step();
    fault_valid = 1'b0;
    step();
    check("restart_left0_a", LeftIn, 0);
    step();
    check("restart_left0_b", LeftIn, 0);
    step();
    check("restart_left_ramp", LeftIn, 16'(ramp - 4));
    fault_clear = 1'b1;
    step();
    fault_clear = 1'b0;
    n = 1;
    while (!fault_ready && n < 20) begin
      step();
      n++;
    end
    check("ready_7_after_clear2", n, 7);

    // Out-of-range locations: one-cycle error pulse, nothing latched.
    for (int i = 0; i < 2; i++) begin
      fault_valid = 1'b1; fault_row = bad_r[i]; fault_col = bad_c[i];
      step();
      fault_valid = 1'b0;
      check("err_pulse", fault_err, 1);
      check("err_ready", fault_ready, 1);
      check("err_w", Weight, 0);
      step();
      check("err_one_cycle", fault_err, 0);
      check("err_still_idle", fault_ready, 1);
    end

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
